// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, port-grant owner,
// queue entry layout and the PC increment.
package ifetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef enum logic {
    G_FETCH = 1'b0,
    G_DBG   = 1'b1
  } grant_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } q_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry shift FIFO of fetched {pc, instr}; head is registered, zero-latency push-to-head.
// Push+pop at any count is legal; push into a full queue without pop is dropped; flush wins.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  q_entry_t                       push_data,
  input  logic                           pop,
  input  logic                           flush,
  output q_entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  q_entry_t        ent0_q, ent0_d;
  q_entry_t        ent1_q, ent1_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;
  logic            do_push;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < FULL_C) || do_pop);

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == '0) ent0_d = push_data;
          else               ent1_d = push_data;
          count_d = count_q + ONE_C;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - ONE_C;
        end
        2'b11: begin
          // Count is unchanged; a lone entry is replaced, a full queue shifts.
          if (count_q == ONE_C) begin
            ent0_d = push_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head  = ent0_q;
  assign count = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: owns the PC, arbitrates the imem read port between fetch and debug, and feeds
// decode from a 2-entry queue; fetch-to-output 1 cycle, fetch stalls when the queue is full and not popped.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL_C = CW'(QDEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e        state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  logic [31:0]   pc_q, pc_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;

  q_entry_t      q_head;
  q_entry_t      q_push_data;
  logic [CW-1:0] q_count;

  logic          pop;
  logic          fetch_want;
  logic          dbg_want;
  logic          grant_fetch;
  logic          grant_dbg;
  logic          drain_empty;
  logic          unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  assign out_valid  = (q_count != '0);
  assign pop        = out_valid & out_ready;
  assign fetch_want = (state_q == RUN) & ~redirect_valid & ((q_count < QFULL_C) | pop);
  assign dbg_want   = dbg_req & ~dbg_ack_q;

  // Last-grant only moves on contested cycles, so contention strictly alternates.
  always_comb begin
    grant_fetch  = 1'b0;
    grant_dbg    = 1'b0;
    last_grant_d = last_grant_q;
    if (fetch_want && dbg_want) begin
      if (last_grant_q == G_FETCH) begin
        grant_dbg    = 1'b1;
        last_grant_d = G_DBG;
      end else begin
        grant_fetch  = 1'b1;
        last_grant_d = G_FETCH;
      end
    end else begin
      grant_fetch = fetch_want;
      grant_dbg   = dbg_want;
    end
  end

  assign imem_addr   = grant_dbg ? dbg_addr : pc_q;
  assign q_push_data = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    pc_d        = pc_q;
    dbg_ack_d   = grant_dbg;
    dbg_rdata_d = dbg_rdata_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (grant_fetch) begin
      pc_d = pc_q + PC_STEP;
    end
    if (grant_dbg) begin
      dbg_rdata_d = imem_rdata;
    end
  end

  // No fetches are issued outside RUN, so only pops and flushes can empty the queue.
  assign drain_empty = redirect_valid | (q_count == '0) | ((q_count == ONE_C) & pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt) state_d = DRAIN;
      end
      DRAIN: begin
        if (!halt)            state_d = RUN;
        else if (drain_empty) state_d = HALTED;
      end
      HALTED: begin
        if (!halt) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      last_grant_q <= G_FETCH;
      pc_q         <= RESET_PC;
      dbg_ack_q    <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pc_q         <= pc_d;
      dbg_ack_q    <= dbg_ack_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  ifetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (grant_fetch),
    .push_data (q_push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count)
  );

  assign out_pc    = q_head.pc;
  assign out_instr = q_head.instr;
  assign halted    = (state_q == HALTED);
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller that sequences the combinational instruction memory. It owns the PC, drives the memory word address, and buffers fetched words in a 2-entry queue behind a valid/ready handshake to decode.
- It also shares the memory read port with a debug/loader read requester.
- It sits between the instruction memory and the decode stage. Branch/jump redirects come from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- QDEPTH, 2, output queue depth; only 2 supported.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- imem_addr  out  32  byte address to instruction memory; memory uses addr[7:2]
- imem_rdata  in  32  combinational read data for imem_addr, same cycle
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  PC of head instruction
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch
- redirect_pc  in  32  new PC; bits [1:0] ignored, forced 0
- halt  in  1  level: stop issuing fetches
- halted  out  1  halt in effect and queue empty
- dbg_req  in  1  level debug read request
- dbg_addr  in  32  debug byte address
- dbg_ack  out  1  one-cycle pulse: dbg_rdata valid
- dbg_rdata  out  32  registered debug read data

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; queue empty; out_valid=0; dbg_ack=0; dbg_rdata=0; halted=0.
  - State RUN; last_grant=FETCH.
  - Reset mid-operation discards queue contents and any pending debug grant.
- FSM states:
  - RUN → DRAIN when halt=1.
  - DRAIN → HALTED when queue empty after this cycle's pop.
  - DRAIN/HALTED → RUN when halt=0.
  - halted=1 only in HALTED (registered).
- Derived signals:
  - pop = out_valid & out_ready.
  - fetch_want = (state==RUN) & !redirect_valid & (count<2 | pop).
  - dbg_want = dbg_req & !dbg_ack.
- Arbitration, one owner of imem_addr per cycle:
  - Only one requester wants → it wins.
  - Both want → the one not equal to last_grant wins; last_grant updates only on contested cycles. This gives strict alternation under contention.
- Fetch grant:
  - imem_addr = pc.
  - At the edge, push {pc, imem_rdata} and set pc <= pc+4, wrapping modulo 2^32.
- Debug grant:
  - imem_addr = dbg_addr.
  - At the edge, dbg_rdata <= imem_rdata and dbg_ack <= 1 for exactly one cycle.
  - Requester must drop or change dbg_req in the ack cycle; no grant is made in the ack cycle.
- No grant: imem_addr = pc.
- Queue:
  - out_valid = count!=0; out_instr/out_pc come from head registers.
  - Push and pop in the same cycle are legal at any count, including count 2.
  - Never overflows; pop on empty is ignored.
- Redirect priority:
  - redirect_valid outranks push, pop and halt for PC/queue.
  - Queue is cleared (count=0) at the edge; pc <= {redirect_pc[31:2],2'b00}; no fetch that cycle.
  - A debug grant may still occur in the redirect cycle.
  - Redirect while DRAIN/HALTED updates pc only.
- Latency and throughput:
  - First out_valid is the cycle after reset release.
  - Fetch-to-output is 1 cycle.
  - Sustained 1 instruction/cycle with out_ready=1 and no debug traffic.
  - Each debug grant costs one fetch slot under contention.

Decomposition:
- Package ifetch_pkg:
  - state enum {RUN, DRAIN, HALTED}
  - grant enum {G_FETCH, G_DBG}
  - struct q_entry_t {pc[31:0], instr[31:0]}
  - localparam PC_STEP=4
- Sub-module ifetch_queue: 2-entry FIFO of q_entry_t with push, pop, flush and count, async active-low reset.
- Controller holds the FSM, arbiter and PC.

Test Plan:
- Reset release, out_ready=1, memory word n = n → out_pc 0,4,8,… and out_instr 0,1,2,… on consecutive cycles; out_valid first high 1 cycle after release.
- out_ready=0 for 5 cycles → count saturates at 2, pc stops at 8, imem_addr=8; out_ready=1 → PCs 0,4,8 delivered with no gap or duplicate.
- Queue full with pop, redirect_valid pulse with redirect_pc=32'h23 → next out_valid cycle shows out_pc=0x20; no pre-redirect entry ever appears.
- dbg_req=1, dbg_addr=0x10 while fetch busy → grants alternate; dbg_ack pulses 1 cycle after grant with dbg_rdata=word 4; fetch resumes next cycle.
- halt=1 with 2 queued, out_ready=1 → both drain, halted=1 two cycles later, imem_addr steady at pc; halt=0 → fetch resumes at same pc.
- reset_n asserted mid-stream (between edges) → out_valid and dbg_ack drop immediately; pc=RESET_PC after release.
